// File: rtl/pmp_checker.sv
// Sequential PMP access checker. A request snapshots the address, access type,
// privilege and the full PMP configuration. The checker then walks the entries
// one per cycle, and the lowest-index match decides the result. The result is
// held on the resp_* outputs until the consumer accepts it.
module pmp_checker #(
    parameter int unsigned NUM_ENTRIES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [63:0]               req_addr,
    input  logic [1:0]                req_type,
    input  logic [1:0]                req_priv,
    input  logic [63:0]               pmpcfg0,
    input  logic [64*NUM_ENTRIES-1:0] pmpaddr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_allowed,
    output logic                      resp_fault,
    output logic [3:0]                resp_cause,
    output logic [2:0]                resp_entry,
    output logic                      resp_matched,
    output logic                      busy
);

    // Word-address width: pmpaddr holds address bits [55:2].
    localparam int unsigned AddrW = 54;

    typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

    localparam logic [1:0] TypeRead    = 2'b00;
    localparam logic [1:0] TypeWrite   = 2'b01;
    localparam logic [1:0] TypeExec    = 2'b10;
    localparam logic [1:0] TypeRsvd    = 2'b11;
    localparam logic [1:0] PrivMachine = 2'b11;

    localparam logic [1:0] AOff   = 2'b00;
    localparam logic [1:0] ATor   = 2'b01;
    localparam logic [1:0] ANa4   = 2'b10;
    localparam logic [1:0] ANapot = 2'b11;

    localparam logic [3:0] CauseNone  = 4'd0;
    localparam logic [3:0] CauseExec  = 4'd2;
    localparam logic [3:0] CauseRead  = 4'd6;
    localparam logic [3:0] CauseWrite = 4'd8;

    localparam logic [2:0] LastIdx = 3'(NUM_ENTRIES - 1);

    state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic capture;

    // Snapshot of the request and configuration taken at accept.
    logic [AddrW-1:0] addr_q;
    logic [1:0]       type_q;
    logic [1:0]       priv_q;
    logic [63:0]      cfg_q;
    logic [AddrW-1:0] pmpaddr_q [NUM_ENTRIES];

    logic       resp_allowed_q, resp_allowed_d;
    logic       resp_fault_q, resp_fault_d;
    logic [3:0] resp_cause_q, resp_cause_d;
    logic [2:0] resp_entry_q, resp_entry_d;
    logic       resp_matched_q, resp_matched_d;

    logic [7:0]       cur_cfg;
    logic [AddrW-1:0] cur_top;
    logic [AddrW-1:0] cur_lo;
    logic [AddrW-1:0] napot_mask;
    logic             entry_hit;
    logic             perm_bit;
    logic             is_machine;
    logic             check_allowed;
    logic [3:0]       check_cause;

    // Bits that carry no meaning for the check.
    logic [NUM_ENTRIES*10-1:0] unused_pmpaddr_hi;
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_unused
        assign unused_pmpaddr_hi[10*g +: 10] = pmpaddr[64*g+AddrW +: 10];
    end
    logic unused_bits;
    assign unused_bits = ^{unused_pmpaddr_hi, req_addr[63:56], req_addr[1:0], cur_cfg[6:5]};

    // Snapshot registers: loaded only when a request is accepted.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= req_addr[55:2];
            type_q <= req_type;
            priv_q <= req_priv;
            cfg_q  <= pmpcfg0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                pmpaddr_q[i] <= pmpaddr[64*i +: AddrW];
            end
        end
    end

    // Address match for the entry currently under scan.
    always_comb begin
        cur_cfg    = cfg_q[{idx_q, 3'b000} +: 8];
        cur_top    = pmpaddr_q[idx_q];
        cur_lo     = (idx_q == 3'd0) ? '0 : pmpaddr_q[idx_q - 3'd1];
        // Trailing ones plus the first zero; all-ones pmpaddr wraps to a full mask.
        napot_mask = cur_top ^ (cur_top + AddrW'(1));
        entry_hit  = 1'b0;
        unique case (cur_cfg[4:3])
            AOff:   entry_hit = 1'b0;
            ATor:   entry_hit = (addr_q >= cur_lo) && (addr_q < cur_top);
            ANa4:   entry_hit = (addr_q == cur_top);
            ANapot: entry_hit = (addr_q | napot_mask) == (cur_top | napot_mask);
        endcase
    end

    // Permission decision for the current scan step (match or final miss).
    always_comb begin
        is_machine = (priv_q == PrivMachine);
        case (type_q)
            TypeRead:  perm_bit = cur_cfg[0];
            TypeWrite: perm_bit = cur_cfg[1];
            TypeExec:  perm_bit = cur_cfg[2];
            default:   perm_bit = 1'b0;
        endcase

        if (type_q == TypeRsvd) begin
            check_allowed = 1'b0;
        end else if (entry_hit) begin
            // Machine mode bypasses unlocked entries.
            check_allowed = (is_machine && !cur_cfg[7]) || perm_bit;
        end else begin
            check_allowed = is_machine;
        end

        if (check_allowed) begin
            check_cause = CauseNone;
        end else if (type_q == TypeExec) begin
            check_cause = CauseExec;
        end else if (type_q == TypeWrite) begin
            check_cause = CauseWrite;
        end else begin
            check_cause = CauseRead;
        end
    end

    // FSM next-state, scan index and response capture.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        capture        = 1'b0;
        resp_allowed_d = resp_allowed_q;
        resp_fault_d   = resp_fault_q;
        resp_cause_d   = resp_cause_q;
        resp_entry_d   = resp_entry_q;
        resp_matched_d = resp_matched_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    capture = 1'b1;
                    idx_d   = 3'd0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (entry_hit || (idx_q == LastIdx)) begin
                    state_d        = StResp;
                    resp_allowed_d = check_allowed;
                    resp_fault_d   = !check_allowed;
                    resp_cause_d   = check_cause;
                    resp_entry_d   = entry_hit ? idx_q : 3'd0;
                    resp_matched_d = entry_hit;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            idx_q          <= 3'd0;
            resp_allowed_q <= 1'b0;
            resp_fault_q   <= 1'b0;
            resp_cause_q   <= 4'd0;
            resp_entry_q   <= 3'd0;
            resp_matched_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            resp_allowed_q <= resp_allowed_d;
            resp_fault_q   <= resp_fault_d;
            resp_cause_q   <= resp_cause_d;
            resp_entry_q   <= resp_entry_d;
            resp_matched_q <= resp_matched_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign resp_valid   = (state_q == StResp);
    assign resp_allowed = resp_allowed_q;
    assign resp_fault   = resp_fault_q;
    assign resp_cause   = resp_cause_q;
    assign resp_entry   = resp_entry_q;
    assign resp_matched = resp_matched_q;

endmodule

// File: tb/tb_pmp_checker.sv
// Bench for pmp_checker: directed cases with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_pmp_checker;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_addr;
    logic [1:0]   req_type;
    logic [1:0]   req_priv;
    logic [63:0]  pmpcfg0;
    logic [511:0] pmpaddr;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_allowed;
    logic         resp_fault;
    logic [3:0]   resp_cause;
    logic [2:0]   resp_entry;
    logic         resp_matched;
    logic         busy;

    pmp_checker #(.NUM_ENTRIES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_type    (req_type),
        .req_priv    (req_priv),
        .pmpcfg0     (pmpcfg0),
        .pmpaddr     (pmpaddr),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_allowed(resp_allowed),
        .resp_fault  (resp_fault),
        .resp_cause  (resp_cause),
        .resp_entry  (resp_entry),
        .resp_matched(resp_matched),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       allowed;
        logic [3:0] cause;
        logic [2:0] entry;
        logic       matched;
        logic [3:0] lat;      // cycle (accept cycle = 0) in which resp_valid first shows
    } exp_t;

    // Reference: regions as [base, base+size) word ranges, first hit wins.
    function automatic exp_t ref_model(input logic [63:0] a, input logic [1:0] t,
                                       input logic [1:0] p, input logic [63:0] cfg,
                                       input logic [511:0] pa);
        exp_t r;
        longint unsigned w, top, lo, base, size;
        logic [7:0] c, hitc;
        bit hit, perm, machine;
        int ones;
        r = '0;
        hitc = '0;
        w = 0;
        w[53:0] = a[55:2];
        lo = 0;
        for (int i = 0; i < 8; i++) begin
            c = cfg[8*i +: 8];
            top = 0;
            top[53:0] = pa[64*i +: 54];
            hit = 1'b0;
            case (c[4:3])
                2'b01: hit = (lo <= w) && (w < top);
                2'b10: hit = (w == top);
                2'b11: begin
                    ones = 0;
                    while (ones < 54 && top[ones]) ones++;
                    if (ones == 54) begin
                        hit = 1'b1;
                    end else begin
                        size = 64'd1 << (ones + 1);
                        base = top & ~(size - 64'd1);
                        hit  = (w >= base) && (w < base + size);
                    end
                end
                default: hit = 1'b0;
            endcase
            if (hit && !r.matched) begin
                r.matched = 1'b1;
                r.entry   = 3'(i);
                hitc      = c;
            end
            lo = top;
        end
        machine = (p == 2'b11);
        perm = (t == 2'b00) ? hitc[0] : (t == 2'b01) ? hitc[1] : hitc[2];
        if (t == 2'b11)     r.allowed = 1'b0;
        else if (r.matched) r.allowed = (machine && !hitc[7]) || perm;
        else                r.allowed = machine;
        r.cause = r.allowed ? 4'd0 : (t == 2'b10) ? 4'd2 : (t == 2'b01) ? 4'd8 : 4'd6;
        r.lat   = r.matched ? 4'(r.entry) + 4'd2 : 4'd9;
        return r;
    endfunction

    // Model: phase 0 idle, 1 checking, 2 responding.
    int   m_phase = 0;
    int   m_cnt   = 0;
    exp_t m_exp   = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_cnt   <= 0;
        end else if (m_phase == 0) begin
            if (req_valid) begin
                m_exp   <= ref_model(req_addr, req_type, req_priv, pmpcfg0, pmpaddr);
                m_cnt   <= 1;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (m_cnt == int'(m_exp.lat) - 1) m_phase <= 2;
            else m_cnt <= m_cnt + 1;
        end else begin
            if (resp_ready) m_phase <= 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_req_ready", 64'(req_ready), 64'(m_phase == 0));
            chk("m_busy", 64'(busy), 64'(m_phase != 0));
            chk("m_resp_valid", 64'(resp_valid), 64'(m_phase == 2));
            if (m_phase == 2) begin
                chk("m_allowed", 64'(resp_allowed), 64'(m_exp.allowed));
                chk("m_fault", 64'(resp_fault), 64'(!m_exp.allowed));
                chk("m_cause", 64'(resp_cause), 64'(m_exp.cause));
                chk("m_entry", 64'(resp_entry), 64'(m_exp.entry));
                chk("m_matched", 64'(resp_matched), 64'(m_exp.matched));
            end
        end
    end

    int         cap_lat;
    logic       cap_allowed, cap_fault, cap_matched;
    logic [3:0] cap_cause;
    logic [2:0] cap_entry;

    task automatic rand_cfg_inputs();
        pmpcfg0 = {$urandom, $urandom};
        for (int j = 0; j < 16; j++) pmpaddr[32*j +: 32] = $urandom;
        req_addr = {$urandom, $urandom};
    endtask

    // Called just after a falling edge with the DUT idle.
    task automatic issue(input logic [63:0] a, input logic [1:0] t, input logic [1:0] p,
                         input int hold, input bit scramble);
        int c;
        req_addr  = a;
        req_type  = t;
        req_priv  = p;
        req_valid = 1'b1;
        @(posedge clk);
        c = 0;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                req_valid = 1'b0;
                if (scramble) rand_cfg_inputs();
            end
            if (resp_valid === 1'b1) break;
        end
        if (resp_valid !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL resp_timeout: no resp_valid after %0d cycles, required by cycle 9", c);
        end
        cap_lat = c;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(req_ready), 64'(0));
        end
        cap_allowed = resp_allowed;
        cap_fault   = resp_fault;
        cap_cause   = resp_cause;
        cap_entry   = resp_entry;
        cap_matched = resp_matched;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic expect_resp(input string nm, input int lat, input bit al, input int cause,
                               input int entry, input bit matched);
        chk({nm, "_latency"}, 64'(cap_lat), 64'(lat));
        chk({nm, "_allowed"}, 64'(cap_allowed), 64'(al));
        chk({nm, "_fault"}, 64'(cap_fault), 64'(!al));
        chk({nm, "_cause"}, 64'(cap_cause), 64'(cause));
        chk({nm, "_entry"}, 64'(cap_entry), 64'(entry));
        chk({nm, "_matched"}, 64'(cap_matched), 64'(matched));
    endtask

    task automatic clear_cfg();
        pmpcfg0 = '0;
        pmpaddr = '0;
    endtask

    task automatic set_entry(input int i, input logic [7:0] c, input logic [63:0] v);
        pmpcfg0[8*i +: 8]  = c;
        pmpaddr[64*i +: 64] = v;
    endtask

    initial begin
        longint unsigned prev;
        logic [63:0] a;
        logic [63:0] v;
        int sh;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_type   = '0;
        req_priv   = '0;
        resp_ready = 1'b0;
        clear_cfg();
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_allowed", 64'(resp_allowed), 64'(0));
        chk("rst_fault", 64'(resp_fault), 64'(0));
        chk("rst_cause", 64'(resp_cause), 64'(0));
        chk("rst_entry", 64'(resp_entry), 64'(0));
        chk("rst_matched", 64'(resp_matched), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 64'(req_ready), 64'(1));

        // NAPOT 4 KiB region at 0x8000_0000, user read.
        set_entry(0, 8'h1B, 64'h2000_01FF);
        issue(64'h8000_0F00, 2'b00, 2'b00, 0, 1'b0);
        expect_resp("napot", 2, 1'b1, 0, 0, 1'b1);
        // Same check with the configuration scrambled after accept.
        issue(64'h8000_0F00, 2'b00, 2'b00, 0, 1'b1);
        expect_resp("snapshot", 2, 1'b1, 0, 0, 1'b1);

        // TOR on entry 1, write without W.
        clear_cfg();
        set_entry(0, 8'h00, 64'h2000_0000);
        set_entry(1, 8'h0D, 64'h2000_0400);
        issue(64'h8000_0800, 2'b01, 2'b00, 0, 1'b0);
        expect_resp("tor", 3, 1'b0, 8, 1, 1'b1);

        // All entries off.
        clear_cfg();
        issue(64'h1000, 2'b10, 2'b11, 0, 1'b0);
        expect_resp("off_m", 9, 1'b1, 0, 0, 1'b0);
        issue(64'h1000, 2'b10, 2'b00, 0, 1'b0);
        expect_resp("off_u", 9, 1'b0, 2, 0, 1'b0);

        // Empty TOR range at entry 0 never matches.
        set_entry(0, 8'h0F, 64'h0);
        issue(64'h0, 2'b00, 2'b00, 0, 1'b0);
        expect_resp("tor_empty", 9, 1'b0, 6, 0, 1'b0);

        // Locked NA4 without permissions binds machine mode; unlocked does not.
        clear_cfg();
        set_entry(0, 8'h90, 64'h400);
        issue(64'h1000, 2'b00, 2'b11, 0, 1'b0);
        expect_resp("locked", 2, 1'b0, 6, 0, 1'b1);
        set_entry(0, 8'h10, 64'h400);
        issue(64'h1000, 2'b00, 2'b11, 0, 1'b0);
        expect_resp("unlocked", 2, 1'b1, 0, 0, 1'b1);
        issue(64'h1000, 2'b11, 2'b11, 0, 1'b0);
        expect_resp("reserved", 2, 1'b0, 6, 0, 1'b1);

        // All-ones NAPOT on entry 3 covers everything.
        clear_cfg();
        set_entry(3, 8'h1C, 64'h003F_FFFF_FFFF_FFFF);
        issue(64'h00F1_2345_6789_ABC0, 2'b10, 2'b00, 0, 1'b0);
        expect_resp("napot_all", 5, 1'b1, 0, 3, 1'b1);

        // Backpressure for 5 cycles.
        clear_cfg();
        set_entry(0, 8'h1B, 64'h2000_01FF);
        issue(64'h8000_0F00, 2'b00, 2'b00, 5, 1'b0);
        expect_resp("bp", 2, 1'b1, 0, 0, 1'b1);

        // Reset in the middle of a scan.
        clear_cfg();
        req_addr  = 64'h1000;
        req_type  = 2'b00;
        req_priv  = 2'b11;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", 64'(req_ready), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_allowed", 64'(resp_allowed), 64'(0));
        for (int i = 0; i < 10; i++) begin
            chk("abort_resp_valid", 64'(resp_valid), 64'(0));
            @(negedge clk);
        end

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            prev = 0;
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 4))
                    0: v = 64'($urandom_range(0, 300));
                    1: v = 64'(prev + 64'($urandom_range(0, 80)));
                    2: begin
                        sh = $urandom_range(0, 7);
                        v = (64'($urandom_range(0, 300)) >> (sh + 1)) << (sh + 1);
                        v = v | ((64'd1 << sh) - 64'd1);
                    end
                    3: v = 64'h003F_FFFF_FFFF_FFFF;
                    default: v = {$urandom, $urandom};
                endcase
                v[63:54] = 10'($urandom);
                pmpaddr[64*i +: 64] = v;
                pmpcfg0[8*i +: 8]   = 8'($urandom);
                prev = 0;
                prev[53:0] = v[53:0];
            end
            if ($urandom_range(0, 7) == 0) begin
                a = {$urandom, $urandom};
            end else begin
                a = '0;
                a[55:2]  = 54'($urandom_range(0, 320));
                a[1:0]   = 2'($urandom);
                a[63:56] = 8'($urandom);
            end
            issue(a, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
